// File: rtl/image_pkg.sv
// Shared types and constants for the image container write path.
package image_pkg;

    localparam int unsigned DATA_WIDTH_8  = 8;
    localparam int unsigned DATA_WIDTH_16 = 16;

    typedef logic [DATA_WIDTH_8-1:0]  pixel_t;
    typedef logic [DATA_WIDTH_16-1:0] coord_t;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/raster_address_gen.sv
// Raster walker: tracks column, row and the linear address of the current row start.
module raster_address_gen
    import image_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     advance,
    input  logic [DATA_WIDTH_16-1:0] ori_x,
    input  logic [DATA_WIDTH_16-1:0] ori_y,
    input  logic [DATA_WIDTH_16-1:0] frame_width,
    input  logic [DATA_WIDTH_16-1:0] win_width,
    input  logic [DATA_WIDTH_16-1:0] win_height,
    output logic [DATA_WIDTH_16-1:0] address,
    output logic                     last
);

    coord_t col_q, col_d;
    coord_t row_q, row_d;
    coord_t row_base_q, row_base_d;
    logic   col_last;

    assign col_last = (col_q == win_width - 16'd1);
    assign last     = col_last && (row_q == win_height - 16'd1);
    assign address  = row_base_q + col_q;

    // Next-state: load the window origin, or step one pixel in raster order.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        if (load) begin
            // Product truncates to 16 bits; address space wraps by design.
            row_base_d = ori_y * frame_width + ori_x;
            col_d      = '0;
            row_d      = '0;
        end else if (advance) begin
            if (col_last) begin
                col_d      = '0;
                row_d      = row_q + 16'd1;
                row_base_d = row_base_q + frame_width;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    // Counter state with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/image_frame_writer.sv
// Writes a raster pixel stream for a window into a frame-sized single-port RAM.
module image_frame_writer
    import image_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH_16-1:0] ori_x,
    input  logic [DATA_WIDTH_16-1:0] ori_y,
    input  logic [DATA_WIDTH_16-1:0] frame_width,
    input  logic [DATA_WIDTH_16-1:0] win_width,
    input  logic [DATA_WIDTH_16-1:0] win_height,
    input  logic                     i_valid,
    input  logic [DATA_WIDTH_8-1:0]  i_pixel,
    output logic                     o_ready,
    output logic                     o_wen,
    output logic [DATA_WIDTH_16-1:0] o_address,
    output logic [DATA_WIDTH_8-1:0]  o_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error
);

    state_e state_q, state_d;
    coord_t ori_x_q, ori_y_q, frame_width_q, win_width_q, win_height_q;
    logic   error_q, error_d;
    logic   latch;
    logic   wen_q;
    coord_t address_q;
    pixel_t data_q;

    logic        accept;
    logic        start_ok;
    logic [16:0] span;
    coord_t      gen_address;
    logic        gen_last;

    // Right edge is checked at 17 bits so ori_x + win_width cannot wrap past the test.
    assign span     = {1'b0, ori_x} + {1'b0, win_width};
    assign start_ok = (win_width != '0) && (win_height != '0) && (span <= {1'b0, frame_width});
    assign accept   = (state_q == StWrite) && i_valid;

    raster_address_gen u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load        (state_q == StSetup),
        .advance     (accept),
        .ori_x       (ori_x_q),
        .ori_y       (ori_y_q),
        .frame_width (frame_width_q),
        .win_width   (win_width_q),
        .win_height  (win_height_q),
        .address     (gen_address),
        .last        (gen_last)
    );

    // FSM next-state, geometry latch request and reject pulse.
    always_comb begin
        state_d = state_q;
        error_d = 1'b0;
        latch   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (start_ok) begin
                        latch   = 1'b1;
                        state_d = StSetup;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StSetup: state_d = StWrite;
            StWrite: if (accept && gen_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State, geometry and error pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            error_q       <= 1'b0;
            ori_x_q       <= '0;
            ori_y_q       <= '0;
            frame_width_q <= '0;
            win_width_q   <= '0;
            win_height_q  <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            if (latch) begin
                ori_x_q       <= ori_x;
                ori_y_q       <= ori_y;
                frame_width_q <= frame_width;
                win_width_q   <= win_width;
                win_height_q  <= win_height;
            end
        end
    end

    // Write-port stage: one cycle after accept; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wen_q     <= 1'b0;
            address_q <= '0;
            data_q    <= '0;
        end else begin
            wen_q <= accept;
            if (accept) begin
                address_q <= gen_address;
                data_q    <= i_pixel;
            end
        end
    end

    assign o_ready   = (state_q == StWrite);
    assign o_busy    = (state_q != StIdle);
    assign o_done    = (state_q == StDone);
    assign o_error   = error_q;
    assign o_wen     = wen_q;
    assign o_address = address_q;
    assign o_data    = data_q;

endmodule

// File: tb/tb_image_frame_writer.sv
// Scoreboard bench for image_frame_writer: stimulus pushes expected writes, monitor pops.
module tb_image_frame_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] ori_x, ori_y, frame_width, win_width, win_height;
    logic        i_valid;
    logic [7:0]  i_pixel;
    logic        o_ready, o_wen, o_busy, o_done, o_error;
    logic [15:0] o_address;
    logic [7:0]  o_data;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;
    int   dones = 0;
    int   err_pulses = 0;
    int   w0, d0, e0;

    logic [15:0] basic_addrs [6] = '{16'd10, 16'd11, 16'd12, 16'd18, 16'd19, 16'd20};
    logic [15:0] wrap_addrs  [4] = '{16'd65280, 16'd65281, 16'd0, 16'd1};
    logic        gap_pat     [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    image_frame_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ori_x       (ori_x),
        .ori_y       (ori_y),
        .frame_width (frame_width),
        .win_width   (win_width),
        .win_height  (win_height),
        .i_valid     (i_valid),
        .i_pixel     (i_pixel),
        .o_ready     (o_ready),
        .o_wen       (o_wen),
        .o_address   (o_address),
        .o_data      (o_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_error     (o_error)
    );

    always #5 clk = ~clk;

    // Monitor: every write must match the head of the scoreboard; done only with a write.
    always @(negedge clk) begin
        if (o_error) err_pulses++;
        if (o_done) dones++;
        if (o_wen) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h done=%0b, required no write",
                         o_address, o_data, o_done);
            end else begin
                mon_e = exp_q.pop_front();
                if ({o_address, o_data, o_done} !== mon_e) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%0h done=%0b, required addr=%0d data=%0h done=%0b",
                             o_address, o_data, o_done, mon_e.addr, mon_e.data, mon_e.done);
                end
            end
        end else if (o_done) begin
            checks++;
            errors++;
            $display("FAIL done_without_write: got o_done=1 o_wen=0, required o_wen=1");
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] ox, input logic [15:0] oy, input logic [15:0] fw,
                            input logic [15:0] ww, input logic [15:0] wh);
        ori_x       = ox;
        ori_y       = oy;
        frame_width = fw;
        win_width   = ww;
        win_height  = wh;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    // Present one pixel, wait (bounded) for the handshake, and record the write it must cause.
    task automatic send(input logic [7:0] pix, input logic [15:0] addr, input logic done);
        int n;
        n       = 0;
        i_valid = 1'b1;
        i_pixel = pix;
        while (!o_ready && n < 16) begin
            step();
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got o_ready=0 for 16 cycles, required 1");
            i_valid = 1'b0;
        end else begin
            exp_q.push_back({addr, pix, done});
            step();
            i_valid = 1'b0;
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_ready"}, o_ready, 0);
        check({tag, "_wen"}, o_wen, 0);
        check({tag, "_address"}, o_address, 0);
        check({tag, "_data"}, o_data, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_error"}, o_error, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; i_valid = 1'b0; i_pixel = '0;
        ori_x = '0; ori_y = '0; frame_width = '0; win_width = '0; win_height = '0;
        step();
        step();
        all_zero("reset");
        reset = 1'b0;
        step();

        // Basic window, continuous stream.
        w0 = writes; d0 = dones;
        do_start(16'd2, 16'd1, 16'd8, 16'd3, 16'd2);
        for (int k = 0; k < 6; k++) send(8'h10 + 8'(k), basic_addrs[k], k == 5);
        check("basic_ready_after_final", o_ready, 0);
        check("basic_busy_in_done", o_busy, 1);
        step();
        step();
        check("basic_busy_idle", o_busy, 0);
        check("basic_writes", writes - w0, 6);
        check("basic_dones", dones - d0, 1);

        // Gapped stream.
        w0 = writes; d0 = dones;
        do_start(16'd2, 16'd1, 16'd8, 16'd3, 16'd2);
        begin
            int k;
            k = 0;
            for (int p = 0; p < 9; p++) begin
                if (gap_pat[p]) begin
                    send(8'h40 + 8'(k), basic_addrs[k], k == 5);
                    k++;
                end else begin
                    i_valid = 1'b0;
                    i_pixel = 8'hEE;
                    step();
                end
            end
        end
        step();
        step();
        check("gap_writes", writes - w0, 6);
        check("gap_dones", dones - d0, 1);

        // Rejects.
        w0 = writes; e0 = err_pulses;
        do_start(16'd2, 16'd1, 16'd8, 16'd0, 16'd2);
        check("rej_w0_error", o_error, 1);
        check("rej_w0_busy", o_busy, 0);
        step();
        check("rej_w0_error_pulse", o_error, 0);
        check("rej_w0_busy_after", o_busy, 0);
        do_start(16'd6, 16'd0, 16'd8, 16'd3, 16'd1);
        check("rej_edge_error", o_error, 1);
        check("rej_edge_busy", o_busy, 0);
        step();
        step();
        step();
        check("rej_writes", writes - w0, 0);
        check("rej_pulses", err_pulses - e0, 2);

        // Window exactly touching the right edge is accepted.
        w0 = writes; e0 = err_pulses;
        do_start(16'd5, 16'd0, 16'd8, 16'd3, 16'd1);
        for (int k = 0; k < 3; k++) send(8'h70 + 8'(k), 16'd5 + 16'(k), k == 2);
        step();
        step();
        check("edge_writes", writes - w0, 3);
        check("edge_no_error", err_pulses - e0, 0);

        // Reset mid-frame, then a fresh frame.
        w0 = writes;
        do_start(16'd2, 16'd1, 16'd8, 16'd3, 16'd2);
        send(8'h30, 16'd10, 1'b0);
        send(8'h31, 16'd11, 1'b0);
        reset = 1'b1;
        step();
        all_zero("midreset");
        reset = 1'b0;
        step();
        step();
        step();
        check("midreset_writes", writes - w0, 2);
        w0 = writes;
        do_start(16'd0, 16'd0, 16'd8, 16'd2, 16'd1);
        send(8'h50, 16'd0, 1'b0);
        send(8'h51, 16'd1, 1'b1);
        step();
        step();
        check("after_reset_writes", writes - w0, 2);

        // Start while busy, including with the final accept, is ignored.
        w0 = writes; e0 = err_pulses;
        do_start(16'd2, 16'd1, 16'd8, 16'd3, 16'd2);
        for (int k = 0; k < 6; k++) begin
            if (k == 2 || k == 5) begin
                ori_x = 16'd0; ori_y = 16'd0; frame_width = 16'd16;
                win_width = 16'd1; win_height = 16'd1;
                start = 1'b1;
            end
            send(8'h60 + 8'(k), basic_addrs[k], k == 5);
            start = 1'b0;
        end
        step();
        step();
        check("busy_start_writes", writes - w0, 6);
        check("busy_start_no_error", err_pulses - e0, 0);
        check("busy_start_idle", o_busy, 0);

        // Address wrap at 2^16.
        w0 = writes;
        do_start(16'd0, 16'd255, 16'd256, 16'd2, 16'd2);
        for (int k = 0; k < 4; k++) send(8'h80 + 8'(k), wrap_addrs[k], k == 3);
        step();
        step();
        check("wrap_writes", writes - w0, 4);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1);
    end

endmodule
